// File: rtl/ga23_sdr_arbiter_if.sv
// SDRAM video read channel between the GA23 tile-fetch arbiter and the
// SDRAM controller: a level request with a held address, answered by a
// one-cycle completion strobe that carries the read word.
interface ga23_sdr_arbiter_if #(
  parameter int AW = 21,
  parameter int DW = 32
);
  logic          sdr_req;
  logic [AW-1:0] sdr_addr;
  logic          sdr_rdy;
  logic [DW-1:0] sdr_data;

  // Arbiter side: issues the request, receives the completion.
  modport master (
    output sdr_req,
    output sdr_addr,
    input  sdr_rdy,
    input  sdr_data
  );

  // Controller side: accepts the request, returns the completion.
  modport slave (
    input  sdr_req,
    input  sdr_addr,
    output sdr_rdy,
    output sdr_data
  );
endinterface

// File: rtl/ga23_sdr_arbiter.sv
// GA23 tile-ROM SDRAM arbiter. Each tile layer fires a one-cycle fetch
// strobe with a word address; the request is latched, the pending requests
// are issued one at a time in round-robin order, and each returned row
// lands in that layer's own held data register with a one-cycle ready
// strobe. Only one SDRAM access is ever outstanding.
module ga23_sdr_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 21,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    rdy,
  output logic [N_REQ*DW-1:0] data,
  output logic [N_REQ-1:0]    overrun,
  ga23_sdr_arbiter_if.master sdr
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [N_REQ-1:0] pend;
  logic [AW-1:0]    paddr [N_REQ];
  logic [IW-1:0]    last;
  logic [IW-1:0]    cur;

  logic             grant_vld;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;
  logic             done;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: IDLE leaves on a grant, WAIT leaves on the completion strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld)   state_d = WAIT;
      WAIT:    if (sdr.sdr_rdy) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Decode: round-robin pick starting one past the last grant, and completion.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (state_q == IDLE) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IW'((int'(last) + k) % N_REQ);
        if (!grant_vld && pend[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    done = (state_q == WAIT) && sdr.sdr_rdy;
  end

  // Address capture: newest request from a layer always replaces its slot.
  // NOTE: the address slots carry no reset; a slot is only ever read while
  // its pend bit is set, and pend itself is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) paddr[i] <= req_addr[i*AW +: AW];
    end
  end

  // Pending/overrun bookkeeping, grant issue, and completion return.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend         <= '0;
      overrun      <= '0;
      last         <= IW'(N_REQ - 1);
      cur          <= '0;
      sdr.sdr_req  <= 1'b0;
      sdr.sdr_addr <= '0;
      rdy          <= '0;
      data         <= '0;
    end else begin
      rdy <= '0;

      // A new strobe wins over the grant clearing the bit; it only counts as
      // an overrun when the older request is being dropped unissued.
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          pend[i] <= 1'b1;
          if (pend[i] && !(grant_vld && grant_idx == IW'(i))) overrun[i] <= 1'b1;
        end else if (grant_vld && grant_idx == IW'(i)) begin
          pend[i] <= 1'b0;
        end
      end

      if (grant_vld) begin
        cur          <= grant_idx;
        last         <= grant_idx;
        sdr.sdr_addr <= paddr[grant_idx];
        sdr.sdr_req  <= 1'b1;
      end

      if (done) begin
        sdr.sdr_req <= 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
          if (cur == IW'(i)) begin
            rdy[i]            <= 1'b1;
            data[i*DW +: DW]  <= sdr.sdr_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Directed bench for the GA23 SDRAM arbiter. Stimulus pushes the expected
// SDRAM addresses and per-layer completions into queues; two monitors pop
// and compare whenever the DUT raises sdr_req or pulses rdy.
module tb_ga23_sdr_arbiter;

  localparam int N_REQ = 3;
  localparam int AW    = 21;
  localparam int DW    = 32;

  typedef struct {
    int            idx;
    logic [DW-1:0] word;
  } rsp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ-1:0]    rdy;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ-1:0]    overrun;

  ga23_sdr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ga23_sdr_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .rdy      (rdy),
    .data     (data),
    .overrun  (overrun),
    .sdr      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr_q [$];
  rsp_t          exp_rsp_q  [$];
  logic [DW-1:0] model      [N_REQ];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N_REQ*DW-1:0] model_flat();
    logic [N_REQ*DW-1:0] v;
    for (int i = 0; i < N_REQ; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req         = '0;
    bus.sdr_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N_REQ; i++) model[i] = '0;
  endtask

  task automatic expect_access(input logic [AW-1:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic expect_rsp(input int idx, input logic [DW-1:0] w);
    rsp_t r;
    r.idx  = idx;
    r.word = w;
    exp_rsp_q.push_back(r);
  endtask

  // One-cycle strobe; addresses outside the strobe are junk on purpose.
  task automatic pulse_req(input logic [N_REQ-1:0] m, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    req      = m;
    req_addr = {a2, a1, a0};
    sync();
    req      = '0;
    req_addr = {3{21'h1F0F0}};
  endtask

  task automatic wait_sdr_req(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.sdr_req !== 1'b1 && waited < 50);
    if (bus.sdr_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL sdr_req_timeout: got no sdr_req within %0d cycles", waited);
    end
  endtask

  // SDRAM model: answer the current access lat cycles after sdr_req rises.
  task automatic serve(input int lat, input logic [DW-1:0] word, output int waited);
    wait_sdr_req(waited);
    if (bus.sdr_req === 1'b1) begin
      repeat (lat - 1) @(posedge clk);
      #1;
      bus.sdr_rdy  = 1'b1;
      bus.sdr_data = word;
      sync();
      bus.sdr_rdy  = 1'b0;
      bus.sdr_data = '0;
    end
  endtask

  // Address monitor: each rising sdr_req must match the next expected address
  // and the address must then hold while sdr_req stays high.
  initial begin
    logic          prev_req;
    logic [AW-1:0] held;
    prev_req = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (bus.sdr_req === 1'b1 && prev_req !== 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sdr_req_unexpected: got access to %0h with none expected", bus.sdr_addr);
        end else begin
          check("sdr_addr", bus.sdr_addr, exp_addr_q.pop_front());
        end
        held = bus.sdr_addr;
      end else if (bus.sdr_req === 1'b1) begin
        check("sdr_addr_stable", bus.sdr_addr, held);
      end
      prev_req = bus.sdr_req;
    end
  end

  // Completion monitor: every rdy pulse must match the next expected layer,
  // and the whole data bus must equal the model (other layers untouched).
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (|rdy === 1'b1) begin
        if (exp_rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdy_unexpected: got rdy=%b with no completion expected", rdy);
        end else begin
          r = exp_rsp_q.pop_front();
          model[r.idx] = r.word;
          check("rdy_vec", rdy, 128'(1) << r.idx);
          check("data_vec", data, model_flat());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int w;
    req          = '0;
    req_addr     = '0;
    bus.sdr_rdy  = 1'b0;
    bus.sdr_data = '0;

    // Reset values, then a single uncontended access.
    do_reset();
    @(negedge clk);
    check("rst_sdr_req",  bus.sdr_req,  0);
    check("rst_sdr_addr", bus.sdr_addr, 0);
    check("rst_rdy",      rdy,          0);
    check("rst_data",     data,         0);
    check("rst_overrun",  overrun,      0);
    sync();
    expect_access(21'h012345);
    expect_rsp(0, 32'hDEADBEEF);
    pulse_req(3'b001, 21'h012345, 21'h0, 21'h0);
    serve(4, 32'hDEADBEEF, w);
    check("first_req_latency", w, 2);
    repeat (3) sync();

    // Simultaneous requests from reset: order 0, 1, 2, back to back.
    do_reset();
    expect_access(21'h000100); expect_rsp(0, 32'hA0000001);
    expect_access(21'h000200); expect_rsp(1, 32'hB0000002);
    expect_access(21'h000300); expect_rsp(2, 32'hC0000003);
    pulse_req(3'b111, 21'h000100, 21'h000200, 21'h000300);
    serve(3, 32'hA0000001, w); check("sim0_latency", w, 2);
    serve(2, 32'hB0000002, w); check("sim1_gap", w, 2);
    serve(5, 32'hC0000003, w); check("sim2_gap", w, 2);
    // Pointer now at 2: requesters 0 and 2 together wrap to 0 first.
    expect_access(21'h0000AB); expect_rsp(0, 32'h11111111);
    expect_access(21'h0002CD); expect_rsp(2, 32'h22222222);
    pulse_req(3'b101, 21'h0000AB, 21'h0, 21'h0002CD);
    serve(1, 32'h11111111, w); check("wrap0_latency", w, 2);
    serve(2, 32'h22222222, w); check("wrap2_gap", w, 2);
    repeat (3) sync();

    // Round robin: after a grant to 1, requesters 0 and 1 go 0 then 1.
    do_reset();
    expect_access(21'h000111); expect_rsp(1, 32'h0BADF00D);
    pulse_req(3'b010, 21'h0, 21'h000111, 21'h0);
    serve(2, 32'h0BADF00D, w);
    expect_access(21'h000400); expect_rsp(0, 32'h44444444);
    expect_access(21'h000500); expect_rsp(1, 32'h55555555);
    pulse_req(3'b011, 21'h000400, 21'h000500, 21'h0);
    serve(3, 32'h44444444, w);
    serve(3, 32'h55555555, w);
    repeat (3) sync();
    check("rr_overrun", overrun, 0);

    // Overwrite while pending: one access to the newer address, overrun set.
    do_reset();
    expect_access(21'h000010); expect_rsp(0, 32'h01010101);
    expect_access(21'h0000BB); expect_rsp(2, 32'hBBBBBBBB);
    pulse_req(3'b001, 21'h000010, 21'h0, 21'h0);
    sync();
    pulse_req(3'b100, 21'h0, 21'h0, 21'h0000AA);
    pulse_req(3'b100, 21'h0, 21'h0, 21'h0000BB);
    serve(4, 32'h01010101, w);
    serve(2, 32'hBBBBBBBB, w);
    repeat (4) sync();
    check("ovw_overrun", overrun, 3'b100);
    check("ovw_idle", bus.sdr_req, 0);

    // Request coincident with its own grant: old then new, no overrun.
    do_reset();
    expect_access(21'h0000C1); expect_rsp(2, 32'hC1C1C1C1);
    expect_access(21'h0000C2); expect_rsp(2, 32'hC2C2C2C2);
    pulse_req(3'b100, 21'h0, 21'h0, 21'h0000C1);
    pulse_req(3'b100, 21'h0, 21'h0, 21'h0000C2);
    serve(2, 32'hC1C1C1C1, w); check("coinc_first", w, 1);
    serve(2, 32'hC2C2C2C2, w); check("coinc_second_gap", w, 2);
    repeat (3) sync();
    check("coinc_overrun", overrun, 0);

    // Reset during WAIT abandons the access; a late completion is ignored.
    do_reset();
    expect_access(21'h000777);
    pulse_req(3'b010, 21'h0, 21'h000777, 21'h0);
    wait_sdr_req(w);
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_sdr_req", bus.sdr_req, 0);
    check("midrst_rdy", rdy, 0);
    sync();
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = 32'h55AA55AA;
    sync();
    bus.sdr_rdy  = 1'b0;
    bus.sdr_data = '0;
    repeat (3) sync();
    check("midrst_data", data, 0);
    check("midrst_idle", bus.sdr_req, 0);

    // Spurious completion in IDLE: nothing changes.
    expect_access(21'h000321); expect_rsp(0, 32'h12345678);
    pulse_req(3'b001, 21'h000321, 21'h0, 21'h0);
    serve(3, 32'h12345678, w);
    repeat (2) sync();
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = $urandom;
    sync();
    bus.sdr_rdy  = 1'b0;
    bus.sdr_data = '0;
    repeat (3) sync();
    check("spur_data", data, model_flat());
    check("spur_idle", bus.sdr_req, 0);

    repeat (5) sync();
    check("addr_queue_drained", exp_addr_q.size(), 0);
    check("rsp_queue_drained",  exp_rsp_q.size(),  0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
